// File: rtl/xbar_rr_switch.sv
// xbar_rr_switch: M-master x S-slave crossbar, per-slave round-robin.
// Ports: clk, reset (sync, active-high), m_* master side, s_* slave side.
//   m_req/m_addr/m_cmd/m_wdata in, m_ack/m_err/m_rdata out (registered);
//   s_req/s_addr/s_cmd/s_wdata out (registered), s_ack/s_rdata in.
module xbar_rr_switch #(
    parameter int MASTERS = 4,
    parameter int SLAVES  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [MASTERS-1:0]          m_req,
    input  logic [MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [MASTERS-1:0]          m_cmd,
    input  logic [MASTERS*DATA_W-1:0]   m_wdata,
    output logic [MASTERS-1:0]          m_ack,
    output logic [MASTERS-1:0]          m_err,
    output logic [MASTERS*DATA_W-1:0]   m_rdata,
    output logic [SLAVES-1:0]           s_req,
    output logic [SLAVES*ADDR_W-1:0]    s_addr,
    output logic [SLAVES-1:0]           s_cmd,
    output logic [SLAVES*DATA_W-1:0]    s_wdata,
    input  logic [SLAVES-1:0]           s_ack,
    input  logic [SLAVES*DATA_W-1:0]    s_rdata
);

    localparam int SEL_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int MW    = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state_q [SLAVES];
    state_t             state_d [SLAVES];
    logic [MW-1:0]      ptr_q   [SLAVES];
    logic [MW-1:0]      ptr_d   [SLAVES];
    logic [MW-1:0]      gnt_q   [SLAVES];
    logic [MW-1:0]      gnt_d   [SLAVES];
    logic [MASTERS-1:0] elig    [SLAVES];
    logic [31:0]        sel     [MASTERS];
    logic [MASTERS-1:0] dec_err;
    logic [MW-1:0]      idx;

    logic [SLAVES-1:0]         s_req_d;
    logic [SLAVES*ADDR_W-1:0]  s_addr_d;
    logic [SLAVES-1:0]         s_cmd_d;
    logic [SLAVES*DATA_W-1:0]  s_wdata_d;
    logic [MASTERS-1:0]        m_ack_d;
    logic [MASTERS-1:0]        m_err_d;
    logic [MASTERS*DATA_W-1:0] m_rdata_d;

    for (genvar i = 0; i < MASTERS; i++) begin : g_sel
        assign sel[i] = 32'(m_addr[i*ADDR_W + ADDR_W - 1 -: SEL_W]);
    end

    // A master being acked this cycle is about to drop its request, so it
    // must not be granted again (or raise a second decode error).
    always_comb begin
        dec_err = '0;
        for (int k = 0; k < SLAVES; k++) begin
            elig[k] = '0;
        end
        for (int i = 0; i < MASTERS; i++) begin
            dec_err[i] = m_req[i] && !m_ack[i] && (sel[i] >= 32'(SLAVES));
            for (int k = 0; k < SLAVES; k++) begin
                elig[k][i] = m_req[i] && !m_ack[i] && (sel[i] == 32'(k));
            end
        end
    end

    always_comb begin
        s_req_d   = s_req;
        s_addr_d  = s_addr;
        s_cmd_d   = s_cmd;
        s_wdata_d = s_wdata;
        m_ack_d   = dec_err;
        m_err_d   = dec_err;
        m_rdata_d = '0;
        idx       = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (dec_err[i]) begin
                m_rdata_d[i*DATA_W +: DATA_W] = '1;
            end
        end
        for (int k = 0; k < SLAVES; k++) begin
            state_d[k] = state_q[k];
            ptr_d[k]   = ptr_q[k];
            gnt_d[k]   = gnt_q[k];
            unique case (state_q[k])
                IDLE: begin
                    if (|elig[k]) begin
                        // Scan downward so the nearest candidate after ptr
                        // is written last and wins.
                        for (int j = MASTERS; j >= 1; j--) begin
                            idx = MW'((int'(ptr_q[k]) + j) % MASTERS);
                            if (elig[k][idx]) begin
                                gnt_d[k] = idx;
                            end
                        end
                        ptr_d[k]   = gnt_d[k];
                        state_d[k] = BUSY;
                        s_req_d[k] = 1'b1;
                        s_cmd_d[k] = m_cmd[gnt_d[k]];
                        s_addr_d[k*ADDR_W +: ADDR_W] =
                            m_addr[gnt_d[k]*ADDR_W +: ADDR_W];
                        s_wdata_d[k*DATA_W +: DATA_W] =
                            m_wdata[gnt_d[k]*DATA_W +: DATA_W];
                    end
                end
                BUSY: begin
                    if (s_ack[k]) begin
                        state_d[k]        = IDLE;
                        s_req_d[k]        = 1'b0;
                        m_ack_d[gnt_q[k]] = 1'b1;
                        m_rdata_d[gnt_q[k]*DATA_W +: DATA_W] =
                            s_rdata[k*DATA_W +: DATA_W];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SLAVES; k++) begin
                state_q[k] <= IDLE;
                ptr_q[k]   <= MW'(MASTERS - 1);
                gnt_q[k]   <= '0;
            end
            s_req   <= '0;
            s_addr  <= '0;
            s_cmd   <= '0;
            s_wdata <= '0;
            m_ack   <= '0;
            m_err   <= '0;
            m_rdata <= '0;
        end else begin
            for (int k = 0; k < SLAVES; k++) begin
                state_q[k] <= state_d[k];
                ptr_q[k]   <= ptr_d[k];
                gnt_q[k]   <= gnt_d[k];
            end
            s_req   <= s_req_d;
            s_addr  <= s_addr_d;
            s_cmd   <= s_cmd_d;
            s_wdata <= s_wdata_d;
            m_ack   <= m_ack_d;
            m_err   <= m_err_d;
            m_rdata <= m_rdata_d;
        end
    end

endmodule
